// File: rtl/player_pose_ctrl.sv
// player_pose_ctrl: grid position and heading for the raycaster.
// Forward steps are bounds-checked, then confirmed by a map query.
module player_pose_ctrl #(
  parameter int COORD_W     = 4,
  parameter int MAP_W       = 16,
  parameter int MAP_H       = 16,
  parameter int START_X     = 1,
  parameter int START_Y     = 1,
  parameter int START_DIR   = 0,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rotateN90_press,
  input  logic               forward_press,
  input  logic               rotate90_press,
  output logic               wall_req,
  output logic [COORD_W-1:0] wall_x,
  output logic [COORD_W-1:0] wall_y,
  input  logic               wall_ack,
  input  logic               wall_hit,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         heading,
  output logic               busy,
  output logic               moved,
  output logic               bumped
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(MAP_H - 1);
  localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
  localparam logic [CNT_W-1:0]   N_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   N_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE,
    QUERY
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic [1:0]         heading_q, heading_d;
  logic [COORD_W-1:0] wall_x_q, wall_x_d;
  logic [COORD_W-1:0] wall_y_q, wall_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               moved_q, moved_d;
  logic               bumped_q, bumped_d;

  logic [2:0]         press;
  logic [COORD_W-1:0] tgt_x;
  logic [COORD_W-1:0] tgt_y;
  logic               oob;

  assign press = {rotateN90_press, forward_press, rotate90_press};

  // Target cell one step along the heading, and whether it leaves the map.
  always_comb begin
    tgt_x = pos_x_q;
    tgt_y = pos_y_q;
    oob   = 1'b0;
    case (heading_q)
      2'd0: begin
        oob   = (pos_y_q == '0);
        tgt_y = pos_y_q - C_ONE;
      end
      2'd1: begin
        oob   = (pos_x_q == X_MAX);
        tgt_x = pos_x_q + C_ONE;
      end
      2'd2: begin
        oob   = (pos_y_q == Y_MAX);
        tgt_y = pos_y_q + C_ONE;
      end
      default: begin
        oob   = (pos_x_q == '0);
        tgt_x = pos_x_q - C_ONE;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    heading_d = heading_q;
    wall_x_d  = wall_x_q;
    wall_y_d  = wall_y_q;
    cnt_d     = cnt_q;
    moved_d   = 1'b0;
    bumped_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Only a single press is a command; anything else is a no-op.
        case (press)
          3'b001: heading_d = heading_q + 2'd1;
          3'b100: heading_d = heading_q - 2'd1;
          3'b010: begin
            if (oob) begin
              bumped_d = 1'b1;
            end else begin
              wall_x_d = tgt_x;
              wall_y_d = tgt_y;
              cnt_d    = '0;
              state_d  = QUERY;
            end
          end
          default: ;
        endcase
      end
      QUERY: begin
        if (wall_ack) begin
          state_d = IDLE;
          if (wall_hit) begin
            bumped_d = 1'b1;
          end else begin
            pos_x_d = wall_x_q;
            pos_y_d = wall_y_q;
            moved_d = 1'b1;
          end
        end else if (cnt_q == N_LAST) begin
          state_d  = IDLE;
          bumped_d = 1'b1;
        end else begin
          cnt_d = cnt_q + N_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pos_x_q   <= COORD_W'(START_X);
      pos_y_q   <= COORD_W'(START_Y);
      heading_q <= 2'(START_DIR);
      wall_x_q  <= '0;
      wall_y_q  <= '0;
      cnt_q     <= '0;
      moved_q   <= 1'b0;
      bumped_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      heading_q <= heading_d;
      wall_x_q  <= wall_x_d;
      wall_y_q  <= wall_y_d;
      cnt_q     <= cnt_d;
      moved_q   <= moved_d;
      bumped_q  <= bumped_d;
    end
  end

  assign wall_req = (state_q == QUERY);
  assign busy     = (state_q == QUERY);
  assign wall_x   = wall_x_q;
  assign wall_y   = wall_y_q;
  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign heading  = heading_q;
  assign moved    = moved_q;
  assign bumped   = bumped_q;

endmodule

// File: tb/tb_player_pose_ctrl.sv
// Bench for player_pose_ctrl: directed plan steps, then random
// commands checked against a cell/heading model.
module tb_player_pose_ctrl;
  localparam int MW = 16;
  localparam int MH = 16;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       rn90, fwd, r90;
  logic       ack, hit;
  logic       wreq, busy, moved, bumped;
  logic [3:0] wx, wy, px, py;
  logic [1:0] hd;

  int errors = 0;
  int checks = 0;
  int mx, my, mh;

  always #5 clk = ~clk;

  player_pose_ctrl dut (
    .clk(clk), .rst(rst),
    .rotateN90_press(rn90), .forward_press(fwd), .rotate90_press(r90),
    .wall_req(wreq), .wall_x(wx), .wall_y(wy),
    .wall_ack(ack), .wall_hit(hit),
    .pos_x(px), .pos_y(py), .heading(hd),
    .busy(busy), .moved(moved), .bumped(bumped)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pose(input string tag);
    chk({tag, ".x"}, 32'(px), mx);
    chk({tag, ".y"}, 32'(py), my);
    chk({tag, ".hd"}, 32'(hd), mh);
  endtask

  // Cell in front of the model player, and whether it is on the map.
  task automatic ahead(output int nx, output int ny, output bit inb);
    int dx[4] = '{0, 1, 0, -1};
    int dy[4] = '{-1, 0, 1, 0};
    nx  = mx + dx[mh];
    ny  = my + dy[mh];
    inb = (nx >= 0) && (nx < MW) && (ny >= 0) && (ny < MH);
  endtask

  task automatic press(input logic [2:0] p);
    {rn90, fwd, r90} = p;
    tick();
    {rn90, fwd, r90} = 3'b000;
  endtask

  // Forward step answered after `wait_cyc` idle QUERY cycles.
  task automatic step(input int wait_cyc, input bit h, input string tag);
    int nx, ny;
    bit inb;
    ahead(nx, ny, inb);
    press(3'b010);
    if (!inb) begin
      chk({tag, ".oob_bump"}, 32'(bumped), 1);
      chk({tag, ".oob_req"}, 32'(wreq), 0);
      return;
    end
    chk({tag, ".req"}, 32'(wreq), 1);
    chk({tag, ".wx"}, 32'(wx), nx);
    chk({tag, ".wy"}, 32'(wy), ny);
    for (int i = 0; i < wait_cyc; i++) begin
      if ($urandom_range(0, 3) == 0) r90 = 1'b1;
      tick();
      r90 = 1'b0;
    end
    ack = 1'b1;
    hit = h;
    tick();
    ack = 1'b0;
    hit = 1'b0;
    if (!h) begin
      mx = nx;
      my = ny;
    end
    chk({tag, ".moved"}, 32'(moved), !h);
    chk({tag, ".bumped"}, 32'(bumped), h);
    chk({tag, ".req_fall"}, 32'(wreq), 0);
  endtask

  initial begin
    logic [2:0] noop[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    int nx, ny;
    bit inb;
    {rn90, fwd, r90, ack, hit} = 5'b0;
    rst = 1'b1;
    #1;
    mx = 1; my = 1; mh = 0;
    chk_pose("rst");
    chk("rst.req", 32'(wreq), 0);
    chk("rst.wx", 32'(wx), 0);
    chk("rst.wy", 32'(wy), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.moved", 32'(moved), 0);
    chk("rst.bumped", 32'(bumped), 0);
    #1 rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      press(3'b001);
      mh = (mh + 1) % 4;
      chk("rot.hd", 32'(hd), mh);
      chk("rot.busy", 32'(busy), 0);
    end
    press(3'b100);
    mh = 3;
    chk("rotn.hd", 32'(hd), 3);
    chk("rotn.busy", 32'(busy), 0);
    press(3'b001);
    press(3'b001);
    mh = 1;

    press(3'b010);
    chk("step.req", 32'(wreq), 1);
    chk("step.busy", 32'(busy), 1);
    chk("step.wx", 32'(wx), 2);
    chk("step.wy", 32'(wy), 1);
    tick();
    tick();
    chk("step.req_hold", 32'(wreq), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    mx = 2;
    chk_pose("step");
    chk("step.moved", 32'(moved), 1);
    chk("step.bumped", 32'(bumped), 0);
    chk("step.req_fall", 32'(wreq), 0);
    tick();
    chk("step.moved_once", 32'(moved), 0);

    press(3'b010);
    press(3'b001);
    ack = 1'b1;
    hit = 1'b1;
    tick();
    {ack, hit} = 2'b00;
    chk_pose("wall");
    chk("wall.bumped", 32'(bumped), 1);
    chk("wall.moved", 32'(moved), 0);
    tick();
    chk("wall.bumped_once", 32'(bumped), 0);

    press(3'b001);
    press(3'b001);
    mh = 3;
    step(0, 1'b0, "w1");
    step(1, 1'b0, "w2");
    chk("edge.x", 32'(px), 0);
    press(3'b010);
    chk("edge.bumped", 32'(bumped), 1);
    chk("edge.req", 32'(wreq), 0);
    chk("edge.busy", 32'(busy), 0);
    tick();
    chk("edge.req2", 32'(wreq), 0);
    press(3'b111);
    chk_pose("all3");
    chk("all3.req", 32'(wreq), 0);
    chk("all3.bumped", 32'(bumped), 0);

    press(3'b001);
    mh = 0;
    press(3'b010);
    for (int k = 1; k < TO; k++) tick();
    chk("to.early_bump", 32'(bumped), 0);
    chk("to.early_req", 32'(wreq), 1);
    tick();
    chk("to.bumped", 32'(bumped), 1);
    chk("to.req", 32'(wreq), 0);
    chk_pose("to");

    press(3'b010);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst.req", 32'(wreq), 0);
    chk("arst.busy", 32'(busy), 0);
    mx = 1; my = 1; mh = 0;
    #1 rst = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_pose("arst");
    chk("arst.moved", 32'(moved), 0);
    chk("arst.req2", 32'(wreq), 0);

    for (int n = 0; n < 300; n++) begin
      int c;
      c = $urandom_range(0, 5);
      if (c == 0) begin
        ack = 1'($urandom_range(0, 1));
        hit = 1'($urandom_range(0, 1));
        press(3'b001);
        {ack, hit} = 2'b00;
        mh = (mh + 1) % 4;
      end else if (c == 1) begin
        press(3'b100);
        mh = (mh + 3) % 4;
      end else if (c == 2) begin
        press(noop[$urandom_range(0, 4)]);
        chk("rnd.noop_req", 32'(wreq), 0);
      end else if (c == 3) begin
        ahead(nx, ny, inb);
        press(3'b010);
        if (inb) begin
          for (int k = 1; k < TO; k++) tick();
          tick();
          chk("rnd.to_bump", 32'(bumped), 1);
        end
      end else begin
        step($urandom_range(0, TO - 2), 1'($urandom_range(0, 1)), "rnd");
      end
      chk("rnd.excl", 32'(moved & bumped), 0);
      chk_pose("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
